asend_mc_fsm: RTL and testbench
===============================

Name: asend_mc_fsm

Overview:
- Multi-channel successor to the single-channel send/ack FSM.
- CH independent sender channels each capture a DW-bit payload on asend, then present aready low while busy.
- A round-robin arbiter serialises pending channels onto one shared four-phase req/ack link.
- Adds ack timeout, bounded retry, and a per-channel sticky error flag.

Parameters:
CH, 4, number of sender channels (>=2)
DW, 8, payload width per channel
TIMEOUT, 15, cycles in REQ without ack before retry; 0 disables timeout
MAX_RETRY, 3, retries after first attempt before abort
CW, $clog2(CH), channel index width (derived, not overridden)

Ports:
aclk  in  1  clock; all state updates on rising edge
arst_n  in  1  asynchronous active-low reset
asend  in  CH  per-channel send strobe; sampled only when that channel's aready=1
adata  in  CH*DW  per-channel payload; channel i occupies bits [i*DW +: DW]
aready  out  CH  per-channel ready; 1 = idle, can accept asend
aerr  out  CH  per-channel sticky abort flag
link_req  out  1  four-phase request to shared link
link_data  out  DW  payload of granted channel; stable while link_req=1
link_ch  out  CW  index of granted channel; stable while link_req=1
link_ack  in  1  four-phase acknowledge from link

Behaviour:
- Clock is aclk. Reset is asynchronous and active-low on arst_n. All registers clear immediately when arst_n=0.
- Reset values:
  - aready = all 1s; aerr = 0; link_req = 0; link_data = 0; link_ch = 0.
  - rr pointer = 0; retry count = 0; timeout counter = 0; link FSM = IDLE.
- Channel side, each channel independent:
  - asend[i]=1 while aready[i]=1 latches adata slice i into the hold register at that edge. aready[i]=0 from the next cycle. pending[i] is set.
  - asend[i] while aready[i]=0 is ignored. Captured data is not overwritten.
  - An accepted asend[i] clears aerr[i] at the same edge.
- Link FSM states: IDLE, REQ, ACKED, BACKOFF.
  - IDLE:
    - If any pending channel exists, grant the first pending at or after rr (wrapping CH-1 -> 0).
    - At that edge: link_ch = grant, link_data = held payload, link_req = 1, timeout counter = 0, retry = 0. Go to REQ.
    - Latency: asend accepted at edge t gives link_req=1 after edge t+1 at the earliest.
  - REQ:
    - link_ack=1 -> link_req = 0, go to ACKED.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> link_req = 0, retry++, go to BACKOFF.
    - Else counter++.
    - Ack and timeout in the same cycle: ack wins.
  - ACKED:
    - Wait for link_ack=0. At that edge: pending[grant] = 0, aready[grant] = 1 next cycle, rr = grant+1 (mod CH), go to IDLE.
  - BACKOFF:
    - Wait for link_ack=0; a late ack here is ignored as a transfer.
    - Then if retry <= MAX_RETRY: link_req = 1, counter = 0, go to REQ for the same channel (grant held, data unchanged).
    - Else abort: aerr[grant] = 1, pending[grant] = 0, aready[grant] = 1, rr = grant+1, go to IDLE.
- Minimum transfer: 4 cycles IDLE->REQ->ACKED->IDLE with an immediate ack/drop.
- Next grant can issue in the cycle after returning to IDLE (no back-to-back bypass).
- link_data and link_ch change only on IDLE->REQ transitions.
- Channel asends during an active transfer only set pending. They never disturb the grant.
- All CH channels pending: served in rr order; each channel is served once per rotation (no starvation).
- Reset mid-transfer: link_req drops asynchronously, all pending transfers are discarded, all aready return to 1.

Test Plan:
- Single send: asend[0]=1, adata[0]=8'hA5; ack rises 2 cycles after req, falls 1 cycle later -> link_ch=0, link_data=A5 held while req=1; aready[0] low until the cycle after ack falls; aerr=0.
- Fairness: asend[3:0]=4'b1111 same cycle, ack after 1 cycle each -> grants in order 0,1,2,3. Then asend[1],asend[0] together with rr=0 -> grant 0 then 1.
- Ignored strobe: pulse asend[2] with a new adata while aready[2]=0 -> transferred data equals the first captured value; only one transfer occurs.
- Timeout/retry recovery: TIMEOUT=15, MAX_RETRY=3, ack withheld for 2 attempts -> req drops after 15 cycles twice and reasserts with the same data; the 3rd attempt acked -> aerr=0.
- Abort: ack never asserted -> 4 attempts of 15 cycles each, then aerr[g]=1 and aready[g]=1. A next accepted asend[g] clears aerr[g].
- Async reset: assert arst_n=0 mid-REQ between edges -> link_req=0 and aready=all 1s immediately; after release, no stale transfer is issued.

Source files
------------

// File: rtl/asend_mc_fsm_if.sv
//------------------------------------------------------------------------------
// asend_mc_fsm_if
//   Bundle of the sender-channel and shared-link signals of asend_mc_fsm.
//   Revision: 1.0
//
//   Signals
//     asend      per-channel send strobe            (env -> fsm)
//     adata      per-channel payload, CH*DW packed  (env -> fsm)
//     aready     per-channel idle flag              (fsm -> env)
//     aerr       per-channel sticky abort flag      (fsm -> env)
//     link_req   four-phase request                 (fsm -> link)
//     link_data  payload of the granted channel     (fsm -> link)
//     link_ch    index of the granted channel       (fsm -> link)
//     link_ack   four-phase acknowledge             (link -> fsm)
//
//   Modports
//     master  environment side (senders plus link responder)
//     slave   the arbitrating FSM
//------------------------------------------------------------------------------
`default_nettype none

interface asend_mc_fsm_if #(
  parameter int CH = 4,
  parameter int DW = 8
);
  localparam int CW = $clog2(CH);

  logic [CH-1:0]    asend;
  logic [CH*DW-1:0] adata;
  logic [CH-1:0]    aready;
  logic [CH-1:0]    aerr;
  logic             link_req;
  logic [DW-1:0]    link_data;
  logic [CW-1:0]    link_ch;
  logic             link_ack;

  modport master (
    output asend, adata, link_ack,
    input  aready, aerr, link_req, link_data, link_ch
  );

  modport slave (
    input  asend, adata, link_ack,
    output aready, aerr, link_req, link_data, link_ch
  );
endinterface

`default_nettype wire

// File: rtl/asend_mc_fsm.sv
//------------------------------------------------------------------------------
// asend_mc_fsm
//   CH independent sender channels each capture a payload on asend and stay
//   busy (aready low) until their payload has been moved over one shared
//   four-phase req/ack link. A round-robin arbiter picks the next pending
//   channel. A request without acknowledge for TIMEOUT cycles is withdrawn
//   and retried up to MAX_RETRY times; after that the transfer is aborted and
//   the channel's sticky aerr flag is raised.
//   Revision: 1.0
//
//   Ports
//     aclk    clock, rising edge
//     arst_n  asynchronous active-low reset
//     bus     asend_mc_fsm_if.slave (channel strobes/data/ready/err, link)
//------------------------------------------------------------------------------
`default_nettype none

module asend_mc_fsm #(
  parameter int CH        = 4,
  parameter int DW        = 8,
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 3
) (
  input  wire logic     aclk,
  input  wire logic     arst_n,
  asend_mc_fsm_if.slave bus
);

  localparam int CW = $clog2(CH);
  // Timeout counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Retry count reaches MAX_RETRY+1 on the attempt that triggers the abort.
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [CW:0]   CH_W      = (CW+1)'(CH);
  localparam logic [CW-1:0] CH_LAST   = CW'(CH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACKED   = 2'd2,
    S_BACKOFF = 2'd3
  } state_e;

  state_e                 state_q,   state_d;
  logic [CH-1:0]          pending_q, pending_d;
  logic [CH-1:0]          aerr_q,    aerr_d;
  logic [CH-1:0][DW-1:0]  hold_q,    hold_d;
  logic [CW-1:0]          grant_q,   grant_d;
  logic [CW-1:0]          rr_q,      rr_d;
  logic [RW-1:0]          retry_q,   retry_d;
  logic [TW-1:0]          cnt_q,     cnt_d;
  logic                   req_q,     req_d;
  logic [DW-1:0]          data_q,    data_d;

  logic [CW-1:0]          pick_w;
  logic [CW-1:0]          rr_next_w;

  // Round-robin pick: first pending channel at or after rr, wrapping.
  // Scanning from the far end down lets the nearest hit overwrite the rest.
  always_comb begin
    logic [CW:0] idx;
    pick_w = rr_q;
    idx    = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (CW+1)'(k);
      if (idx >= CH_W) begin
        idx = idx - CH_W;
      end
      if (pending_q[idx[CW-1:0]]) begin
        pick_w = idx[CW-1:0];
      end
    end
  end

  // Pointer moves one past the channel just finished, so it is served last
  // in the next rotation.
  assign rr_next_w = (grant_q == CH_LAST) ? '0 : grant_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    aerr_d    = aerr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    data_d    = data_q;

    // Channel capture; a busy channel ignores its strobe so held data is kept.
    for (int i = 0; i < CH; i++) begin
      if (bus.asend[i] && !pending_q[i]) begin
        hold_d[i]    = bus.adata[i*DW +: DW];
        pending_d[i] = 1'b1;
        aerr_d[i]    = 1'b0;
      end
    end

    // Capture and link completion never target the same channel: a channel
    // under transfer is pending and so cannot accept a new strobe.
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          grant_d = pick_w;
          data_d  = hold_q[pick_w];
          req_d   = 1'b1;
          cnt_d   = '0;
          retry_d = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (bus.link_ack) begin
          req_d   = 1'b0;
          state_d = S_ACKED;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          req_d   = 1'b0;
          retry_d = retry_q + RW'(1);
          state_d = S_BACKOFF;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_ACKED: begin
        if (!bus.link_ack) begin
          pending_d[grant_q] = 1'b0;
          rr_d               = rr_next_w;
          state_d            = S_IDLE;
        end
      end

      S_BACKOFF: begin
        // Four-phase rule: a late ack must drop before anything else happens;
        // it never counts as a completed transfer.
        if (!bus.link_ack) begin
          if (retry_q <= RETRY_LIM) begin
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            aerr_d[grant_q]    = 1'b1;
            pending_d[grant_q] = 1'b0;
            rr_d               = rr_next_w;
            state_d            = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      aerr_q    <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      aerr_q    <= aerr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      data_q    <= data_d;
    end
  end

  // A channel is ready exactly when it has nothing waiting for the link.
  assign bus.aready    = ~pending_q;
  assign bus.aerr      = aerr_q;
  assign bus.link_req  = req_q;
  assign bus.link_data = data_q;
  assign bus.link_ch   = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_asend_mc_fsm.sv
//------------------------------------------------------------------------------
// tb_asend_mc_fsm
//   Scoreboard bench for asend_mc_fsm. Batches of sends are issued while the
//   link is idle; the reference model orders them round-robin and pushes the
//   expected transfers (channel, data, attempt count, abort) into a queue.
//   A link responder withholds ack for a planned number of attempts, and an
//   independent monitor pops and compares every transfer seen on the link.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_asend_mc_fsm;

  localparam int CH        = 4;
  localparam int DW        = 8;
  localparam int TIMEOUT   = 15;
  localparam int MAX_RETRY = 3;

  logic aclk   = 1'b0;
  logic arst_n = 1'b0;

  always #5 aclk = ~aclk;

  asend_mc_fsm_if #(.CH(CH), .DW(DW)) bus ();

  asend_mc_fsm #(
    .CH       (CH),
    .DW       (DW),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .aclk  (aclk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            attempts;
    bit            abort;
  } exp_t;

  exp_t exp_q[$];
  int   plan_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_m   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit   prev_req  = 1'b0;
  bit   active    = 1'b0;
  bit   ack_seen  = 1'b0;
  exp_t cur;
  int   attempts  = 0;
  int   chk_cnt   = 0;
  int   chk_ch    = 0;
  bit   chk_err   = 1'b0;

  initial begin
    forever begin
      @(negedge aclk);
      if (mon_en) begin
        if (bus.link_req) begin
          if (!prev_req) begin
            ack_seen = 1'b0;
            if (!active) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer ch=%0d data=%0h, none expected",
                         bus.link_ch, bus.link_data);
              end else begin
                cur      = exp_q.pop_front();
                active   = 1'b1;
                attempts = 0;
              end
            end
            attempts++;
          end
          if (active) begin
            check("link_ch", 64'(bus.link_ch), 64'(cur.ch));
            check("link_data", 64'(bus.link_data), 64'(cur.data));
          end
          if (bus.link_ack) ack_seen = 1'b1;
        end else if (prev_req && active) begin
          if (bus.link_ack) ack_seen = 1'b1;
          if (ack_seen || attempts == MAX_RETRY + 1) begin
            check("attempts", 64'(attempts), 64'(cur.attempts));
            check("aborted", 64'(!ack_seen), 64'(cur.abort));
            active  = 1'b0;
            chk_cnt = 6;
            chk_ch  = cur.ch;
            chk_err = cur.abort;
          end
        end
        if (chk_cnt > 0) begin
          chk_cnt--;
          if (chk_cnt == 0) begin
            check("aerr_after", 64'(bus.aerr[chk_ch]), 64'(chk_err));
            check("aready_after", 64'(bus.aready[chk_ch]), 64'd1);
          end
        end
        prev_req = bus.link_req;
      end
    end
  end

  // ---------------- link responder ----------------
  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!bus.link_req && n < 300) begin
      @(negedge aclk);
      n++;
    end
    ok = bus.link_req;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_wait actual=timeout required=link_req high within 300 cycles");
    end
  endtask

  initial begin
    int w;
    int n;
    bit ok;
    bus.link_ack = 1'b0;
    forever begin
      @(negedge aclk);
      if (plan_q.size() > 0) begin
        w = plan_q.pop_front();
        for (int a = 0; a <= MAX_RETRY; a++) begin
          wait_req(ok);
          if (!ok) break;
          if (a < w) begin
            n = 0;
            while (bus.link_req && n < 100) begin
              n++;
              @(negedge aclk);
            end
            check("timeout_len", 64'(n), 64'(TIMEOUT));
          end else begin
            repeat ($urandom_range(0, 3)) @(negedge aclk);
            #1 bus.link_ack = 1'b1;
            n = 0;
            while (bus.link_req && n < 100) begin
              n++;
              @(negedge aclk);
            end
            check("req_drop_on_ack", 64'(bus.link_req), 64'd0);
            repeat ($urandom_range(0, 2)) @(negedge aclk);
            #1 bus.link_ack = 1'b0;
            break;
          end
        end
      end
    end
  end

  // ---------------- stimulus + reference model ----------------
  // wv holds 4 bits per channel: number of attempts the link leaves unacked.
  task automatic run_batch(input logic [CH-1:0] mask, input logic [CH*DW-1:0] data,
                           input logic [4*CH-1:0] wv, input bit lat);
    int   last;
    int   w;
    int   n;
    int   pc;
    exp_t e;
    last = -1;
    pc   = 0;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (rr_m + k) % CH;
      if (mask[c]) begin
        w          = int'(wv[4*c +: 4]);
        e.ch       = c;
        e.data     = data[c*DW +: DW];
        e.abort    = (w > MAX_RETRY);
        e.attempts = e.abort ? MAX_RETRY + 1 : w + 1;
        exp_q.push_back(e);
        plan_q.push_back(w);
        last = c;
      end
    end
    if (last < 0) return;
    rr_m = (last + 1) % CH;

    bus.asend = mask;
    bus.adata = data;
    @(negedge aclk);
    bus.asend = '0;
    check("aready_busy", 64'(bus.aready & mask), 64'd0);
    check("aerr_clear_on_send", 64'(bus.aerr & mask), 64'd0);
    if (lat) check("req_latency_early", 64'(bus.link_req), 64'd0);

    // Strobe a busy channel again with different data: must be ignored.
    for (int k = CH - 1; k >= 0; k--) if (mask[k]) pc = k;
    bus.adata[pc*DW +: DW] = ~data[pc*DW +: DW];
    bus.asend[pc]          = 1'b1;
    @(negedge aclk);
    bus.asend = '0;
    if (lat) check("req_latency", 64'(bus.link_req), 64'd1);

    n = 0;
    while (n < 4000 && !(exp_q.size() == 0 && plan_q.size() == 0 && !active &&
                         chk_cnt == 0 && !bus.link_req && bus.aready == '1)) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL batch_done actual=timeout required=all transfers finished (left %0d)",
               exp_q.size());
    end
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    logic [CH*DW-1:0] d;
    logic [4*CH-1:0]  wv;
    logic [CH-1:0]    m;
    int               r;
    int               n;
    bit               saw;

    bus.asend = '0;
    bus.adata = '0;
    arst_n    = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_aready", 64'(bus.aready), 64'hF);
    check("rst_aerr", 64'(bus.aerr), 64'd0);
    check("rst_link_req", 64'(bus.link_req), 64'd0);
    check("rst_link_data", 64'(bus.link_data), 64'd0);
    check("rst_link_ch", 64'(bus.link_ch), 64'd0);
    arst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge aclk);

    // Single send on channel 0.
    run_batch(4'b0001, {24'h000000, 8'hA5}, 16'h0000, 1'b1);
    // All channels at once, then channels 1 and 0 with rr back at 0.
    run_batch(4'b1111, 32'h44332211, 16'h0000, 1'b0);
    run_batch(4'b0011, 32'h0000BEEF, 16'h0000, 1'b0);
    // Two timeouts then success on channel 2.
    run_batch(4'b0100, 32'h00C30000, 16'h0200, 1'b0);
    // Never acked on channel 3 -> abort; then a fresh send clears aerr.
    run_batch(4'b1000, 32'h5A000000, 16'h4000, 1'b0);
    run_batch(4'b1000, 32'h69000000, 16'h0000, 1'b0);

    for (int it = 0; it < 25; it++) begin
      m = CH'($urandom);
      d = {$urandom};
      for (int c = 0; c < CH; c++) begin
        r = $urandom_range(0, 9);
        wv[4*c +: 4] = (r < 5) ? 4'd0 : 4'(r - 4);
      end
      run_batch(m, d, wv, 1'b0);
    end

    // Asynchronous reset while a request is outstanding and unacked.
    mon_en    = 1'b0;
    bus.adata = 32'h0000_7E00;
    bus.asend = 4'b0010;
    @(negedge aclk);
    bus.asend = '0;
    n = 0;
    while (!bus.link_req && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("rst_mid_req_seen", 64'(bus.link_req), 64'd1);
    repeat (3) @(negedge aclk);
    #2 arst_n = 1'b0;
    #1;
    check("async_rst_req", 64'(bus.link_req), 64'd0);
    check("async_rst_aready", 64'(bus.aready), 64'hF);
    @(negedge aclk);
    arst_n = 1'b1;
    saw    = 1'b0;
    repeat (30) begin
      @(negedge aclk);
      if (bus.link_req) saw = 1'b1;
    end
    check("no_stale_transfer", 64'(saw), 64'd0);
    check("post_rst_aready", 64'(bus.aready), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
